mmio_port_responder: RTL

- Memory-mapped I/O responder on the processor's data-memory bus (Address, WriteData, MemWrite, MemRead, ReadData).
- The processor is the initiator. This block is the target that owns the external PortIn/PortOut pins, a change-capture flag and a one-shot down-timer.
- The top level muxes ReadData from this block over DataMemory when Hit=1.
- Reads are combinational, same cycle, to match the single-cycle datapath. Writes commit on the clock edge.

---
 rtl/mmio_port_pkg.sv | 20 ++
 rtl/mmio_port_responder_if.sv | 13 +
 rtl/mmio_port_responder_port_sync_edge.sv | 21 ++
 rtl/mmio_port_responder.sv | 100 ++++++++++
 4 files changed

// File: rtl/mmio_port_pkg.sv
// Shared constants for the MMIO port responder: register offsets, STATUS bit
// positions and default parameter values.
package mmio_port_pkg;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1001_0000;
  localparam int          DEF_WINDOW_BITS = 5;
  localparam int          DEF_IN_WIDTH    = 8;
  localparam int          DEF_DATA_WIDTH  = 32;

  localparam logic [7:0] OFF_PORT_OUT  = 8'h00;
  localparam logic [7:0] OFF_PORT_IN   = 8'h04;
  localparam logic [7:0] OFF_STATUS    = 8'h08;
  localparam logic [7:0] OFF_CAPTURE   = 8'h0C;
  localparam logic [7:0] OFF_TMR_LOAD  = 8'h10;
  localparam logic [7:0] OFF_TMR_COUNT = 8'h14;
  localparam logic [7:0] OFF_IRQ_EN    = 8'h18;

  localparam int ST_IN_CHANGED  = 0;
  localparam int ST_TMR_EXPIRED = 1;
  localparam int ST_TMR_RUN     = 8;
endpackage

// File: rtl/mmio_port_responder_if.sv
// Data-memory bus as seen by an MMIO target: processor drives the request,
// target returns combinational read data and its window hit.
interface mmio_port_responder_if #(parameter int DATA_WIDTH = 32);
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Hit;

  modport master (output Address, WriteData, MemWrite, MemRead, input ReadData, Hit);
  modport slave  (input Address, WriteData, MemWrite, MemRead, output ReadData, Hit);
endinterface

// File: rtl/mmio_port_responder_port_sync_edge.sv
// Three-flop synchronizer for the external input port; the third stage only
// exists to flag a change of the settled (second-stage) value.
module port_sync_edge #(
  parameter int IN_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] portIn,
  output logic [IN_WIDTH-1:0] syncVal,
  output logic                changed
);
  logic [2:0][IN_WIDTH-1:0] syncPipe;

  always_ff @(posedge clk) begin
    if (!reset) syncPipe <= '0;
    else        syncPipe <= {syncPipe[1:0], portIn};
  end

  assign syncVal = syncPipe[1];
  assign changed = syncPipe[1] != syncPipe[2];
endmodule

// File: rtl/mmio_port_responder.sv
// MMIO target owning PortIn/PortOut, a change-capture flag and a one-shot
// down-timer. Reads are combinational; writes commit on the clock edge.
module mmio_port_responder
  import mmio_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WINDOW_BITS = DEF_WINDOW_BITS,
  parameter int          IN_WIDTH    = DEF_IN_WIDTH,
  parameter int          DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_port_responder_if.slave  bus,
  input  logic [IN_WIDTH-1:0]   PortIn,
  output logic [DATA_WIDTH-1:0] PortOut,
  output logic                  Irq
);
  logic                   hit;
  logic [WINDOW_BITS-1:0] regOff;
  logic                   wrEn, wrPortOut, wrStatus, wrTmrLoad, wrIrqEn;
  logic [IN_WIDTH-1:0]    syncVal, capture;
  logic                   chgPulse;
  logic                   inChanged, tmrExpired, tmrRun, expSet;
  logic [DATA_WIDTH-1:0]  tmrLoad, count;
  logic [1:0]             irqEn;
  logic [1:0]             unusedAddrBits;

  assign unusedAddrBits = bus.Address[1:0];

  assign hit     = bus.Address[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS];
  assign bus.Hit = hit;
  assign regOff  = {bus.Address[WINDOW_BITS-1:2], 2'b00};

  assign wrEn      = bus.MemWrite && hit;
  assign wrPortOut = wrEn && (regOff == WINDOW_BITS'(OFF_PORT_OUT));
  assign wrStatus  = wrEn && (regOff == WINDOW_BITS'(OFF_STATUS));
  assign wrTmrLoad = wrEn && (regOff == WINDOW_BITS'(OFF_TMR_LOAD));
  assign wrIrqEn   = wrEn && (regOff == WINDOW_BITS'(OFF_IRQ_EN));

  port_sync_edge #(.IN_WIDTH(IN_WIDTH)) uSync (
    .clk     (clk),
    .reset   (reset),
    .portIn  (PortIn),
    .syncVal (syncVal),
    .changed (chgPulse)
  );

  // A TMR_LOAD write on the terminal cycle reloads instead of expiring.
  assign expSet = tmrRun && !wrTmrLoad && (count == DATA_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      PortOut    <= '0;
      capture    <= '0;
      inChanged  <= 1'b0;
      tmrExpired <= 1'b0;
      tmrRun     <= 1'b0;
      tmrLoad    <= '0;
      count      <= '0;
      irqEn      <= '0;
      Irq        <= 1'b0;
    end else begin
      if (wrPortOut) PortOut <= bus.WriteData;
      if (wrIrqEn)   irqEn   <= bus.WriteData[1:0];
      if (chgPulse)  capture <= syncVal;
      // Set events take priority over a same-edge write-one-to-clear.
      inChanged  <= chgPulse | (inChanged & ~(wrStatus & bus.WriteData[ST_IN_CHANGED]));
      tmrExpired <= expSet | (tmrExpired & ~(wrStatus & bus.WriteData[ST_TMR_EXPIRED]));
      if (wrTmrLoad) begin
        tmrLoad <= bus.WriteData;
        count   <= bus.WriteData;
        tmrRun  <= |bus.WriteData;
      end else if (tmrRun) begin
        count <= count - DATA_WIDTH'(1);
        if (expSet) tmrRun <= 1'b0;
      end
      Irq <= |({tmrExpired, inChanged} & irqEn);
    end
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.MemRead && hit) begin
      case (regOff)
        WINDOW_BITS'(OFF_PORT_OUT):  bus.ReadData = PortOut;
        WINDOW_BITS'(OFF_PORT_IN):   bus.ReadData = DATA_WIDTH'(syncVal);
        WINDOW_BITS'(OFF_STATUS): begin
          bus.ReadData[ST_IN_CHANGED]  = inChanged;
          bus.ReadData[ST_TMR_EXPIRED] = tmrExpired;
          bus.ReadData[ST_TMR_RUN]     = tmrRun;
        end
        WINDOW_BITS'(OFF_CAPTURE):   bus.ReadData = DATA_WIDTH'(capture);
        WINDOW_BITS'(OFF_TMR_LOAD):  bus.ReadData = tmrLoad;
        WINDOW_BITS'(OFF_TMR_COUNT): bus.ReadData = count;
        WINDOW_BITS'(OFF_IRQ_EN):    bus.ReadData = DATA_WIDTH'(irqEn);
        default:                     bus.ReadData = '0;
      endcase
    end
  end
endmodule
